// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// Cache geometry is set here; all other widths derive from it.
package dcache_pkg;

    localparam int unsigned NUM_LINES      = 16;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned WORD_W         = 32;

    localparam int unsigned WSEL_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFFSET_W = WSEL_W + 2;
    localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W   = WORD_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data storage for the cache: combinational read by index,
// synchronous line fill or single-word store, synchronous clear of valid/dirty.
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_data,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [LINE_W-1:0]   fill_data,
    input  logic                wr_en,
    input  logic [WSEL_W-1:0]   wr_word,
    input  logic [WORD_W-1:0]   wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];

    // Line state bits: reset wins over any concurrent fill or store
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (wr_en) begin
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                if (wr_word == WSEL_W'(w)) begin
                    data_q[index][w*WORD_W +: WORD_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Hits complete in the request cycle; misses stall while whole lines move.
module dcache_direct_mapped
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    state_e state, next_state;

    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] cpu_index;
    logic [WSEL_W-1:0]  cpu_word;
    logic               unused_addr_bits;

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [LINE_W-1:0]  line_data;

    logic               hit_c;
    logic               miss_c;
    logic               fill_en;
    logic               wr_en;

    assign cpu_tag          = cpu_addr[ADDR_W-1 -: TAG_W];
    assign cpu_index        = cpu_addr[OFFSET_W +: INDEX_W];
    assign cpu_word         = cpu_addr[2 +: WSEL_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit_c  = (state == COMPARE) & cpu_req & line_valid & (line_tag == cpu_tag);
    assign miss_c = (state == COMPARE) & cpu_req & ~hit_c;
    assign stall  = cpu_req & ~cpu_ready;

    dcache_line_store u_store (
        .clk       (clk),
        .rst       (rst),
        .index     (cpu_index),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .fill_en   (fill_en),
        .fill_tag  (cpu_tag),
        .fill_data (mem_rdata),
        .wr_en     (wr_en),
        .wr_word   (cpu_word),
        .wr_data   (cpu_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COMPARE;
        end else begin
            state <= next_state;
        end
    end

    // Counters add their event bit every cycle so they wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_count  <= hit_count  + 32'(hit_c);
            miss_count <= miss_count + 32'(miss_c);
        end
    end

    always_comb begin
        next_state = state;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_en    = 1'b0;
        wr_en      = 1'b0;

        case (state)
            COMPARE: begin
                if (hit_c) begin
                    cpu_ready = 1'b1;
                    wr_en     = cpu_we;
                    if (!cpu_we) begin
                        for (int w = 0; w < WORDS_PER_LINE; w++) begin
                            if (cpu_word == WSEL_W'(w)) begin
                                cpu_rdata = line_data[w*WORD_W +: WORD_W];
                            end
                        end
                    end
                end else if (miss_c) begin
                    next_state = (line_valid & line_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, cpu_index, OFFSET_W'(0)};
                mem_wdata = line_data;
                if (mem_ready) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_tag, cpu_index, OFFSET_W'(0)};
                if (mem_ready) begin
                    fill_en    = 1'b1;
                    next_state = COMPARE;
                end
            end
            default: begin
                next_state = COMPARE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Scoreboard bench for dcache_direct_mapped: directed loads/stores with a
// line-wide memory model that records writebacks and checks every transaction.
module tb_dcache_direct_mapped;
    import dcache_pkg::*;

    localparam int unsigned CW = LINE_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [31:0]        cpu_rdata;
    logic               cpu_ready;
    logic               stall;
    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_ready;
    logic [31:0]        hit_count;
    logic [31:0]        miss_count;

    dcache_direct_mapped dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
    } cpu_exp_t;

    typedef struct {
        logic              we;
        logic [31:0]       addr;
        logic              chk;
        logic [LINE_W-1:0] wdata;
    } mem_exp_t;

    cpu_exp_t           cpu_q [$];
    mem_exp_t           mem_q [$];
    logic [LINE_W-1:0]  mem_store [logic [31:0]];
    int                 mem_delay = 2;
    int                 total = 0;
    int                 bad = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        if (mem_store.exists(a)) return mem_store[a];
        if (a == 32'h100) return {32'h44, 32'h33, 32'h22, 32'h11};
        for (int i = 0; i < WORDS_PER_LINE; i++) l[i*32 +: 32] = a + 32'(4 * i);
        return l;
    endfunction

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic chk,
                           input logic [LINE_W-1:0] wdata);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.chk = chk; e.wdata = wdata;
        mem_q.push_back(e);
    endtask

    // Issue one request, wait for cpu_ready, and check cycles spent stalled
    task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_waits);
        cpu_exp_t e;
        int waits;
        e.we = we; e.rdata = exp_rdata;
        cpu_q.push_back(e);
        waits = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        while (!cpu_ready && waits < 60) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("latency", CW'(waits), CW'(exp_waits));
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic check_counts(input logic [31:0] h, input logic [31:0] m);
        check("hit_count", CW'(hit_count), CW'(h));
        check("miss_count", CW'(miss_count), CW'(m));
    endtask

    // CPU-side monitor: pops an expectation on every cpu_ready cycle
    always @(negedge clk) begin
        cpu_exp_t e;
        #2;
        if (!rst) begin
            check("stall", CW'(stall), CW'(cpu_req & ~cpu_ready));
            if (cpu_ready) begin
                check("ready_expected", CW'(cpu_q.size() != 0), CW'(1));
                if (cpu_q.size() != 0) begin
                    e = cpu_q.pop_front();
                    if (!e.we) check("cpu_rdata", CW'(cpu_rdata), CW'(e.rdata));
                end
            end
        end
    end

    // Memory model and memory-side monitor
    initial begin
        logic [31:0]       a;
        logic              w;
        logic [LINE_W-1:0] wd;
        mem_exp_t          me;
        int                k;
        bit                aborted;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_req && !rst) begin
                check("mem_txn_expected", CW'(mem_q.size() != 0), CW'(1));
                if (mem_q.size() != 0) begin
                    me = mem_q.pop_front();
                    check("mem_we", CW'(mem_we), CW'(me.we));
                    check("mem_addr", CW'(mem_addr), CW'(me.addr));
                    if (me.chk) check("mem_wdata", mem_wdata, me.wdata);
                end
                a = mem_addr; w = mem_we; wd = mem_wdata;
                k = 1;
                aborted = 1'b0;
                while (k < mem_delay) begin
                    @(negedge clk);
                    #1;
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("mem_hold", CW'({mem_req, mem_we, stall, mem_addr}), CW'({1'b1, w, 1'b1, a}));
                    k++;
                end
                if (!aborted) begin
                    if (w) mem_store[a] = wd;
                    else mem_rdata = line_of(a);
                    mem_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", CW'({cpu_ready, stall, mem_req, mem_we, mem_addr, cpu_rdata}), CW'(0));
        check_counts(32'd0, 32'd0);

        // cold miss, then store/load hits on the same line
        exp_mem(1'b0, 32'h100, 1'b0, '0);
        cpu_op(1'b0, 32'h104, 32'h0, 32'h22, 3);
        check_counts(32'd1, 32'd1);
        cpu_op(1'b1, 32'h108, 32'hDEADBEEF, 32'h0, 0);
        cpu_op(1'b0, 32'h108, 32'h0, 32'hDEADBEEF, 0);
        check_counts(32'd3, 32'd1);

        // conflict miss on a dirty line: writeback then allocate
        exp_mem(1'b1, 32'h100, 1'b1, {32'h44, 32'hDEADBEEF, 32'h22, 32'h11});
        exp_mem(1'b0, 32'h1100, 1'b0, '0);
        cpu_op(1'b0, 32'h1108, 32'h0, 32'h1108, 5);
        check_counts(32'd4, 32'd2);

        // clean victim; refetched line carries the written-back store
        exp_mem(1'b0, 32'h100, 1'b0, '0);
        cpu_op(1'b0, 32'h108, 32'h0, 32'hDEADBEEF, 3);
        check_counts(32'd5, 32'd3);

        // slow memory
        mem_delay = 5;
        exp_mem(1'b0, 32'h200, 1'b0, '0);
        cpu_op(1'b0, 32'h200, 32'h0, 32'h200, 6);
        check_counts(32'd6, 32'd4);
        mem_delay = 2;

        // store miss merges after refill
        exp_mem(1'b0, 32'h310, 1'b0, '0);
        cpu_op(1'b1, 32'h314, 32'hCAFEF00D, 32'h0, 3);
        cpu_op(1'b0, 32'h314, 32'h0, 32'hCAFEF00D, 0);
        cpu_op(1'b0, 32'h318, 32'h0, 32'h318, 0);
        check_counts(32'd9, 32'd5);

        // hit counter wrap
        @(negedge clk);
        force dut.hit_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.hit_count;
        cpu_op(1'b0, 32'h31C, 32'h0, 32'h31C, 0);
        check_counts(32'd0, 32'd5);

        // reset in the middle of an allocate
        mem_delay = 10;
        exp_mem(1'b0, 32'h400, 1'b0, '0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
        repeat (3) @(negedge clk);
        #1;
        check("mem_req_before_rst", CW'(mem_req), CW'(1));
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check("mem_req_after_rst", CW'({mem_req, cpu_ready}), CW'(0));
        @(negedge clk);
        rst = 1'b0;
        mem_delay = 2;
        exp_mem(1'b0, 32'h400, 1'b0, '0);
        cpu_op(1'b0, 32'h400, 32'h0, 32'h400, 3);
        check_counts(32'd1, 32'd1);
        exp_mem(1'b0, 32'h310, 1'b0, '0);
        cpu_op(1'b0, 32'h314, 32'h0, 32'h314, 3);
        check_counts(32'd2, 32'd2);

        repeat (3) @(negedge clk);
        check("cpu_queue_drained", CW'(cpu_q.size()), CW'(0));
        check("mem_queue_drained", CW'(mem_q.size()), CW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
Direct-mapped, write-back, write-allocate data cache for the MEM stage, directly downstream of the EX-stage ALU. The ALU result is the load/store byte address. The block serves hits with no extra latency and asserts stall to freeze the pipeline on misses. It refills and evicts whole lines over a line-wide main-memory handshake.

Parameters:
NUM_LINES, 16, number of cache lines (power of 2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2)
ADDR_W, 32, byte-address width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cpu_req  input  1  load/store request from MEM stage
cpu_we  input  1  1 = store word, 0 = load word
cpu_addr  input  32  byte address (ALU out); bits [1:0] ignored
cpu_wdata  input  32  store data
cpu_rdata  output  32  load data, valid when cpu_ready=1 and cpu_we=0
cpu_ready  output  1  request completes this cycle
stall  output  1  cpu_req & ~cpu_ready; freezes pipeline
mem_req  output  1  memory transaction request
mem_we  output  1  1 = line writeback, 0 = line fetch
mem_addr  output  32  line-aligned byte address
mem_wdata  output  32*WORDS_PER_LINE  evicted line, word 0 in LSBs
mem_rdata  input  32*WORDS_PER_LINE  fetched line
mem_ready  input  1  one-cycle pulse; transaction done
hit_count  output  32  completed hits (wraps)
miss_count  output  32  misses detected (wraps)

Behaviour:
- Address split for defaults: byte [1:0], word [3:2], index [7:4], tag [31:8]. General form: word = log2(WORDS_PER_LINE) bits, index = log2(NUM_LINES) bits.
- Per line: valid, dirty, tag, data.
- FSM states: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE, no cpu_req: cpu_ready=0, no state change.
- COMPARE, cpu_req, hit (valid & tag match): hit is combinational.
  - cpu_ready=1 in the same cycle.
  - Load: cpu_rdata = addressed word, combinational.
  - Store: word written and dirty set at the clock edge.
  - hit_count increments.
- COMPARE, cpu_req, miss: cpu_ready=0; miss_count increments once per miss.
  - Victim dirty -> WRITEBACK.
  - Victim clean or invalid -> ALLOCATE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line.
  - Hold all mem outputs until mem_ready, then go to ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr = {cpu tag, index, 0}.
  - On mem_ready: write mem_rdata into the line; set valid=1, dirty=0, tag; go to COMPARE.
  - The request then hits. Miss latency = memory cycles + 1; that hit counts in hit_count.
- mem_req deasserts in the cycle after mem_ready. mem_ready outside WRITEBACK/ALLOCATE is ignored.
- While stall=1, the CPU holds cpu_req/cpu_we/cpu_addr/cpu_wdata stable. Changes during a miss are undefined.
- cpu_ready is never asserted outside COMPARE.
- Reset values:
  - State COMPARE; all valid=0, dirty=0.
  - cpu_ready=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, cpu_rdata=0, counters 0.
  - Data/tag arrays need no reset.
- Reset during WRITEBACK/ALLOCATE abandons the transaction. mem_req=0 the cycle after reset is sampled. No line is left valid.
- A store that misses completes only after refill; the store word is merged at the hit in COMPARE.
- Counters wrap 0xFFFFFFFF -> 0.

Decomposition:
- Shared package dcache_pkg: state enum (COMPARE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2); OFFSET_W, INDEX_W, TAG_W, LINE_W derived constants.
- One sub-module, dcache_line_store: valid/dirty/tag/data arrays.
  - Combinational read port by index.
  - Synchronous write port: full-line fill, or single-word write with dirty set.
  - Synchronous clear of valid/dirty on rst.

Test Plan:
- Cold load cpu_addr=0x00000104, memory line at 0x100 = {0x44,0x33,0x22,0x11} (word3..0) -> stall 1, ALLOCATE, mem_addr=0x100, mem_we=0; after mem_ready, cpu_ready=1 with cpu_rdata=0x22; miss_count=1, hit_count=1.
- Store 0xDEADBEEF to 0x108 right after, then load 0x108 -> both complete with cpu_ready the same cycle, no mem_req; load returns 0xDEADBEEF; hit_count=3.
- Load 0x00001108 (same index 0, new tag) -> WRITEBACK first: mem_we=1, mem_addr=0x100, mem_wdata word2=0xDEADBEEF. Then ALLOCATE at mem_addr=0x1100, then a hit.
- Load 0x200 with mem_ready delayed 5 cycles -> mem_req and mem_addr stable all 5 cycles; stall high throughout; exactly one cycle with cpu_ready.
- Assert rst during ALLOCATE -> mem_req=0 next cycle. A following load to the same address misses again (miss_count restarts at 1).
- Preload hit_count=0xFFFFFFFF via forced state, then one hit -> hit_count=0.
